// File: rtl/hs_io_device_if.sv
// Byte-wide processor handshake bundle: request/data from the processor,
// acknowledge/data/interrupt back from the device.
interface hs_io_device_if;
  logic [7:0] cpu_bus_out;
  logic       cpu_hs_out;
  logic [7:0] cpu_bus_in;
  logic       cpu_hs_in;
  logic       ext_int;

  modport master (
    output cpu_bus_out, cpu_hs_out,
    input  cpu_bus_in, cpu_hs_in, ext_int
  );

  modport slave (
    input  cpu_bus_out, cpu_hs_out,
    output cpu_bus_in, cpu_hs_in, ext_int
  );
endinterface

// File: rtl/hs_io_device.sv
// Device-side responder for the processor byte handshake: every request swaps
// one byte between the processor bus and a pair of system-side FIFOs.
module hs_io_device #(
  parameter int         DEPTH      = 4,
  parameter int         INT_THRESH = 1,
  parameter logic [7:0] FILL       = 8'h00
) (
  input  logic                     g_clk,
  input  logic                     g_clr,
  hs_io_device_if.slave            cpu,
  input  logic                     int_en,
  input  logic                     tx_wr,
  input  logic [7:0]               tx_data,
  output logic                     tx_full,
  input  logic                     rx_rd,
  output logic [7:0]               rx_data,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [$clog2(DEPTH):0]   rx_count,
  input  logic                     err_clr,
  output logic                     underrun,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_CNT = CW'(INT_THRESH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t        state, state_next;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CW-1:0] tx_count_next, rx_count_next;
  logic          tx_empty, rx_full;
  logic          exchange, tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]    bus_in_q;
  logic          ext_int_q;
  logic          hs_in;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign rx_data  = rx_mem[rx_rd_ptr];

  // One exchange per request: only taken from IDLE, and stalls while RX has no room.
  assign exchange = (state == IDLE) && cpu.cpu_hs_out && !rx_full;
  assign tx_pop   = exchange && !tx_empty;
  assign tx_push  = tx_wr && !tx_full;
  assign rx_push  = exchange;
  assign rx_pop   = rx_rd && !rx_empty;

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (exchange) state_next = ACK;
      ACK:     if (!cpu.cpu_hs_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hs_in = (state == ACK);
  end

  assign cpu.cpu_hs_in  = hs_in;
  assign cpu.cpu_bus_in = bus_in_q;
  assign cpu.ext_int    = ext_int_q;

  always_comb begin
    tx_count_next = tx_count;
    if (tx_push && !tx_pop)      tx_count_next = tx_count + CNT_ONE;
    else if (tx_pop && !tx_push) tx_count_next = tx_count - CNT_ONE;
  end

  always_comb begin
    rx_count_next = rx_count;
    if (rx_push && !rx_pop)      rx_count_next = rx_count + CNT_ONE;
    else if (rx_pop && !rx_push) rx_count_next = rx_count - CNT_ONE;
  end

  always_ff @(posedge g_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= cpu.cpu_bus_out;
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      tx_count <= tx_count_next;
      rx_count <= rx_count_next;
    end
  end

  // The returned byte is held until the next exchange, not cleared on return to IDLE.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      bus_in_q  <= '0;
      ext_int_q <= 1'b0;
    end else begin
      if (exchange) bus_in_q <= tx_pop ? tx_mem[tx_rd_ptr] : FILL;
      ext_int_q <= int_en && (rx_count_next >= THRESH_CNT);
    end
  end

  // A set event in the same cycle as err_clr takes priority.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (exchange && tx_empty) underrun <= 1'b1;
      else if (err_clr)         underrun <= 1'b0;
      if (tx_wr && tx_full)     overflow <= 1'b1;
      else if (err_clr)         overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs_io_device.sv
// Directed bench for hs_io_device: a queue-based model is compared every cycle,
// and literal expectations pin the model at key points of each scenario.
module tb_hs_io_device;
  localparam int         DEPTH      = 4;
  localparam int         INT_THRESH = 2;
  localparam logic [7:0] FILL       = 8'h00;
  localparam int         CW         = $clog2(DEPTH) + 1;

  logic          g_clk   = 1'b0;
  logic          g_clr   = 1'b0;
  logic          int_en  = 1'b0;
  logic          tx_wr   = 1'b0;
  logic [7:0]    tx_data = 8'h00;
  logic          rx_rd   = 1'b0;
  logic          err_clr = 1'b0;
  logic          tx_full, rx_empty, underrun, overflow;
  logic [7:0]    rx_data;
  logic [CW-1:0] tx_count, rx_count;

  int checks = 0;
  int errors = 0;

  hs_io_device_if cpu_if ();

  hs_io_device #(.DEPTH(DEPTH), .INT_THRESH(INT_THRESH), .FILL(FILL)) dut (
    .g_clk    (g_clk),
    .g_clr    (g_clr),
    .cpu      (cpu_if.slave),
    .int_en   (int_en),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .rx_rd    (rx_rd),
    .rx_data  (rx_data),
    .rx_empty (rx_empty),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .err_clr  (err_clr),
    .underrun (underrun),
    .overflow (overflow)
  );

  always #5 g_clk = ~g_clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: FIFOs as queues, handshake as a single "acknowledged" bit.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_ack   = 1'b0;
  logic [7:0] m_bus   = 8'h00;
  logic       m_ext   = 1'b0;
  logic       m_under = 1'b0;
  logic       m_over  = 1'b0;

  always @(posedge g_clk or negedge g_clr) begin : model_step
    int tx_n;
    int rx_n;
    bit ex;
    if (!g_clr) begin
      m_tx.delete();
      m_rx.delete();
      m_ack = 1'b0; m_bus = 8'h00; m_ext = 1'b0; m_under = 1'b0; m_over = 1'b0;
    end else begin
      tx_n = m_tx.size();
      rx_n = m_rx.size();
      ex   = !m_ack && cpu_if.cpu_hs_out && (rx_n < DEPTH);
      if (err_clr) begin m_under = 1'b0; m_over = 1'b0; end
      if (ex) begin
        if (tx_n > 0) m_bus = m_tx.pop_front();
        else begin m_bus = FILL; m_under = 1'b1; end
      end
      if (tx_wr) begin
        if (tx_n == DEPTH) m_over = 1'b1;
        else m_tx.push_back(tx_data);
      end
      if (rx_rd && rx_n > 0) m_rx.delete(0);
      if (ex) m_rx.push_back(cpu_if.cpu_bus_out);
      m_ack = m_ack ? cpu_if.cpu_hs_out : ex;
      m_ext = int_en && (m_rx.size() >= INT_THRESH);
    end
  end

  always @(posedge g_clk) begin
    #1;
    check_output("hs_in",    cpu_if.cpu_hs_in,  m_ack);
    check_output("bus_in",   cpu_if.cpu_bus_in, m_bus);
    check_output("ext_int",  cpu_if.ext_int,    m_ext);
    check_output("tx_count", tx_count,          m_tx.size());
    check_output("rx_count", rx_count,          m_rx.size());
    check_output("tx_full",  tx_full,           m_tx.size() == DEPTH);
    check_output("rx_empty", rx_empty,          m_rx.size() == 0);
    check_output("underrun", underrun,          m_under);
    check_output("overflow", overflow,          m_over);
    if (m_rx.size() > 0) check_output("rx_data", rx_data, m_rx[0]);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge g_clk);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1; tx_data = b;
    tick();
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic wait_hs(input logic level, input int budget);
    int n = 0;
    while (cpu_if.cpu_hs_in !== level && n < budget) begin
      tick();
      n++;
    end
    check_output(level ? "hs_in_rise_wait" : "hs_in_fall_wait", cpu_if.cpu_hs_in, level);
  endtask

  // One full four-phase handshake carrying byte b from the processor.
  task automatic apply_stimulus(input logic [7:0] b);
    cpu_if.cpu_bus_out = b;
    cpu_if.cpu_hs_out  = 1'b1;
    tick();
    wait_hs(1'b1, 8);
    cpu_if.cpu_hs_out = 1'b0;
    tick();
    wait_hs(1'b0, 8);
  endtask

  task automatic drain_rx();
    int n = 0;
    while (rx_empty !== 1'b1 && n < 2 * DEPTH) begin
      pop_rx();
      n++;
    end
    check_output("drain_rx_empty", rx_empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_rx [4];
    cpu_if.cpu_bus_out = 8'h00;
    cpu_if.cpu_hs_out  = 1'b0;
    tick(2);
    check_output("rst_hs_in",    cpu_if.cpu_hs_in,  1'b0);
    check_output("rst_bus_in",   cpu_if.cpu_bus_in, 8'h00);
    check_output("rst_ext_int",  cpu_if.ext_int,    1'b0);
    check_output("rst_counts",   {tx_count, rx_count}, '0);
    check_output("rst_rx_empty", rx_empty, 1'b1);
    check_output("rst_tx_full",  tx_full,  1'b0);
    check_output("rst_flags",    {underrun, overflow}, 2'b00);
    g_clr = 1'b1;
    tick();

    $display("[TB] basic exchange");
    push_tx(8'hA5);
    cpu_if.cpu_bus_out = 8'h3C;
    cpu_if.cpu_hs_out  = 1'b1;
    tick();
    check_output("hs_rise_latency", cpu_if.cpu_hs_in, 1'b1);
    cpu_if.cpu_hs_out = 1'b0;
    tick();
    check_output("hs_fall_latency", cpu_if.cpu_hs_in, 1'b0);
    check_output("ex1_bus_in",   cpu_if.cpu_bus_in, 8'hA5);
    check_output("ex1_rx_data",  rx_data,  8'h3C);
    check_output("ex1_rx_count", rx_count, 1);
    check_output("ex1_tx_count", tx_count, 0);

    $display("[TB] underrun");
    apply_stimulus(8'h77);
    check_output("ur_bus_in",   cpu_if.cpu_bus_in, 8'h00);
    check_output("ur_underrun", underrun, 1'b1);
    pulse_err_clr();
    check_output("ur_cleared",  underrun, 1'b0);
    drain_rx();

    $display("[TB] RX full stall");
    for (int i = 1; i <= 4; i++) apply_stimulus(8'(i));
    cpu_if.cpu_bus_out = 8'h05;
    cpu_if.cpu_hs_out  = 1'b1;
    tick(3);
    check_output("stall_hs_in",    cpu_if.cpu_hs_in, 1'b0);
    check_output("stall_rx_count", rx_count, 4);
    check_output("stall_head",     rx_data,  8'h01);
    pop_rx();
    wait_hs(1'b1, 4);
    cpu_if.cpu_hs_out = 1'b0;
    tick();
    wait_hs(1'b0, 4);
    exp_rx = '{8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 4; i++) begin
      check_output("stall_drain_order", rx_data, exp_rx[i]);
      pop_rx();
    end

    $display("[TB] TX overflow and wrap");
    pulse_err_clr();
    for (int i = 0; i < 5; i++) begin
      push_tx(8'h11 + 8'(i));
      if (i == 3) begin
        check_output("ovf_full_at_4", tx_full,  1'b1);
        check_output("ovf_not_yet",   overflow, 1'b0);
      end
    end
    check_output("ovf_flag",     overflow, 1'b1);
    check_output("ovf_tx_count", tx_count, 4);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h80 + 8'(i));
      check_output("tx_order", cpu_if.cpu_bus_in, 8'h11 + 8'(i));
    end
    drain_rx();
    push_tx(8'h21);
    push_tx(8'h22);
    apply_stimulus(8'h90);
    check_output("wrap_byte0", cpu_if.cpu_bus_in, 8'h21);
    apply_stimulus(8'h91);
    check_output("wrap_byte1", cpu_if.cpu_bus_in, 8'h22);
    check_output("wrap_no_underrun", underrun, 1'b0);
    drain_rx();

    $display("[TB] interrupt threshold");
    pulse_err_clr();
    int_en = 1'b1;
    apply_stimulus(8'h31);
    check_output("int_after_1", cpu_if.ext_int, 1'b0);
    apply_stimulus(8'h32);
    check_output("int_after_2", cpu_if.ext_int, 1'b1);
    pop_rx();
    check_output("int_after_rd", cpu_if.ext_int, 1'b0);
    int_en = 1'b0;
    apply_stimulus(8'h33);
    check_output("int_disabled", cpu_if.ext_int, 1'b0);
    check_output("int_disabled_count", rx_count, 2);
    drain_rx();

    $display("[TB] reset during ACK");
    for (int i = 0; i < 5; i++) push_tx(8'h40 + 8'(i));
    cpu_if.cpu_bus_out = 8'h99;
    cpu_if.cpu_hs_out  = 1'b1;
    tick();
    check_output("pre_rst_in_ack", cpu_if.cpu_hs_in, 1'b1);
    check_output("pre_rst_ovf",    overflow, 1'b1);
    #2 g_clr = 1'b0;
    #1;
    check_output("mid_rst_hs_in",  cpu_if.cpu_hs_in, 1'b0);
    check_output("mid_rst_counts", {tx_count, rx_count}, '0);
    check_output("mid_rst_flags",  {underrun, overflow}, 2'b00);
    check_output("mid_rst_bus_in", cpu_if.cpu_bus_in, 8'h00);
    tick();
    g_clr = 1'b1;
    wait_hs(1'b1, 4);
    check_output("post_rst_rx_data",  rx_data, 8'h99);
    check_output("post_rst_bus_in",   cpu_if.cpu_bus_in, FILL);
    check_output("post_rst_underrun", underrun, 1'b1);
    cpu_if.cpu_hs_out = 1'b0;
    tick();
    wait_hs(1'b0, 4);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_io_device.md
Name: hs_io_device

Overview:
- Device-side partner of the processor's byte-wide I/O handshake. It is the responder to the processor's `hs_out` request and drives the processor's `hs_in` acknowledge.
- Every handshake transaction is a full-duplex byte exchange:
  - the byte on the processor's `bus_out` is captured into an RX FIFO;
  - the head of a TX FIFO is presented on the processor's `bus_in`.
- A system-side FIFO interface loads outgoing bytes and drains received bytes.
- A threshold-based level interrupt drives the processor's `ext_int`.

Parameters:
- DEPTH, 4, entries per FIFO (power of 2, ≥2).
- INT_THRESH, 1, RX occupancy at or above which `ext_int` asserts (1..DEPTH).
- FILL, 8'h00, byte returned when the TX FIFO is empty at exchange.

Ports:
- g_clk  in  1  clock, rising edge.
- g_clr  in  1  asynchronous active-low reset.
- cpu_bus_out  in  8  processor output data (processor `bus_out`).
- cpu_hs_out  in  1  processor request (processor `hs_out`).
- cpu_bus_in  out  8  data to processor (processor `bus_in`).
- cpu_hs_in  out  1  acknowledge to processor (processor `hs_in`).
- ext_int  out  1  interrupt to processor (processor `ext_int`).
- int_en  in  1  interrupt enable.
- tx_wr  in  1  push `tx_data` into TX FIFO.
- tx_data  in  8  byte to send.
- tx_full  out  1  TX FIFO full.
- rx_rd  in  1  pop RX FIFO.
- rx_data  out  8  RX FIFO head (valid when !rx_empty).
- rx_empty  out  1  RX FIFO empty.
- tx_count  out  log2(DEPTH)+1  TX occupancy.
- rx_count  out  log2(DEPTH)+1  RX occupancy.
- err_clr  in  1  clears sticky error flags.
- underrun  out  1  sticky: exchange occurred with TX empty.
- overflow  out  1  sticky: `tx_wr` while `tx_full`.

Behaviour:
- Reset (`g_clr`=0, async):
  - `cpu_bus_in`=0, `cpu_hs_in`=0, `ext_int`=0.
  - Both FIFOs empty: counts 0, `rx_empty`=1, `tx_full`=0.
  - `underrun`=0, `overflow`=0, state IDLE.
  - Reset mid-handshake drops `cpu_hs_in` immediately. A byte already captured is lost.
- States: IDLE, ACK.
- IDLE:
  - Condition: `cpu_hs_out`=1 and RX not full. All of the following happen on that edge:
    - push `cpu_bus_out` into RX;
    - if TX non-empty, pop TX and register its head on `cpu_bus_in`;
    - else register FILL on `cpu_bus_in` and set `underrun`;
    - set `cpu_hs_in`=1 and go to ACK.
  - Latency: `cpu_hs_in` is high in the cycle after `cpu_hs_out` is first sampled high.
  - If RX is full, `cpu_hs_in` stays 0 (processor stalls) until `rx_rd` frees an entry.
- ACK:
  - Hold `cpu_hs_in`=1.
  - When `cpu_hs_out` is sampled 0: `cpu_hs_in`=0, go to IDLE.
  - `cpu_hs_out` remaining high causes no further capture.
- `cpu_bus_in` holds its value until the next exchange. It is not cleared on return to IDLE.
- Only one exchange per 4-phase cycle. Minimum transaction is 2 cycles of `cpu_hs_in` activity after request.
- FIFOs:
  - Circular buffers with wrapping read/write pointers.
  - Full/empty derive from registered counts.
  - `tx_wr` when `tx_full` is ignored and sets `overflow`. This holds even if a TX pop occurs that same cycle.
  - `rx_rd` when `rx_empty` is ignored, with no flag.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle are both performed and the count is unchanged. This covers `tx_wr` during an exchange pop, and exchange push during `rx_rd`.
  - `tx_wr` into an empty TX in the same cycle as an exchange: the exchange sees empty, FILL is sent, and the new byte is stored.
- `rx_data` is the combinational view of the RX head entry.
- `ext_int`:
  - Registered: `ext_int` <= `int_en` & (`rx_count_next` ≥ INT_THRESH).
  - Level-sensitive; deasserts the cycle after occupancy drops below threshold.
- `err_clr` clears both sticky flags. A set event in the same cycle wins.

Test Plan:
- Reset, then write `tx_data`=8'hA5, then one exchange with `cpu_bus_out`=8'h3C.
  - `cpu_hs_in` rises 1 cycle after request and falls 1 cycle after `cpu_hs_out` falls.
  - `cpu_bus_in`=8'hA5, `rx_data`=8'h3C, `rx_count`=1, `tx_count`=0.
- Exchange with TX empty: `cpu_bus_in`=8'h00, `underrun`=1.
  - `err_clr` pulse returns `underrun` to 0.
- Four exchanges (8'h01..8'h04) with no `rx_rd`, then a fifth request:
  - `cpu_hs_in` stays 0 and `rx_count`=4.
  - One `rx_rd` returns 8'h01; the fifth exchange then acks, capturing 8'h05.
- Write 5 bytes into TX with DEPTH=4: `tx_full`=1 after the 4th, `overflow`=1.
  - Exchanges return the first 4 bytes in order, including across pointer wrap after a refill.
- `int_en`=1, INT_THRESH=2:
  - `ext_int` is 0 after the 1st exchange and 1 after the 2nd;
  - after one `rx_rd`, `ext_int` is 0 next cycle;
  - with `int_en`=0, `ext_int` stays 0.
- Assert `g_clr` while in ACK: `cpu_hs_in`, counts and flags go to 0 immediately.
  - After release, a held `cpu_hs_out`=1 starts a fresh exchange.
